// File: rtl/piezo_burst_ctrl_if.sv
// Host-side register bus for piezo_burst_ctrl: decoded SPI writes in, result and status out.
interface piezo_burst_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             iWR_STB;
  logic [7:0]       iCMD;
  logic [7:0]       iDATA;
  logic [CNT_W-1:0] oTOF;
  logic [7:0]       oSTATUS;
  logic             oBUSY;
  logic             oDONE;

  modport master (
    output iWR_STB, iCMD, iDATA,
    input  oTOF, oSTATUS, oBUSY, oDONE
  );

  modport slave (
    input  iWR_STB, iCMD, iDATA,
    output oTOF, oSTATUS, oBUSY, oDONE
  );
endinterface

// File: rtl/piezo_burst_ctrl.sv
// Piezo node sequencer: programmable TX burst, receiver blanking, then first-arrival timestamping.
//
// state  | meaning
// IDLE   | waiting for start; TX driver off
// TX     | square-wave burst, driver enabled
// BLANK  | driver off, ignore ringing for BLANK cycles
// LISTEN | waiting for synchronized RX rising edge or timeout
// DONE   | one-cycle completion pulse
module piezo_burst_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic              iCLK,
  input  logic              iRESETn,
  piezo_burst_ctrl_if.slave bus,
  input  logic              iPIEZO_RX,
  output logic              oPIEZO_TX,
  output logic              oPIEZO_EN
);

  typedef enum logic [2:0] {IDLE, TX, BLANK, LISTEN, DONE} state_t;

  state_t           state, stateNext;
  logic [7:0]       halfCfg, pulsesCfg, blankLoCfg, blankHiCfg, toutHiCfg;
  logic [7:0]       halfW, pulsesW, halfCnt;
  logic [8:0]       halfIdx;
  logic [15:0]      blankCnt;
  logic [CNT_W-1:0] toutW, cnt, tof;
  logic             txLevel;
  logic             rxMeta, rxSync, rxPrev, rxEdge;
  logic             hit, tout, aborted, overrun, paramErr;
  logic             busy, done;

  logic       grpHit, wrCtrl, startReq, abortReq, clearReq;
  logic       idle, paramOk, startAcc, abortNow;
  logic       halfTick, lastHalf, timeoutHit, cntSat;
  logic [2:0] sub;
  logic       unusedCmd;

  assign unusedCmd  = bus.iCMD[7];
  assign sub        = bus.iCMD[2:0];
  assign grpHit     = bus.iWR_STB && (bus.iCMD[6:3] == 4'b0001);
  assign wrCtrl     = grpHit && (sub == 3'd5);
  // abort in the same write suppresses start entirely
  assign startReq   = wrCtrl && bus.iDATA[0] && !bus.iDATA[1];
  assign abortReq   = wrCtrl && bus.iDATA[1];
  assign clearReq   = wrCtrl && bus.iDATA[2];
  assign idle       = (state == IDLE);
  assign paramOk    = (halfCfg != 8'd0) && (pulsesCfg != 8'd0);
  assign startAcc   = startReq && idle && paramOk;
  assign abortNow   = abortReq && !idle;
  assign halfTick   = (halfCnt == halfW - 8'd1);
  assign lastHalf   = (halfIdx == {pulsesW, 1'b0} - 9'd1);
  assign timeoutHit = (cnt >= toutW);
  assign cntSat     = &cnt;

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      halfCfg    <= 8'd4;
      pulsesCfg  <= 8'd8;
      blankLoCfg <= 8'd0;
      blankHiCfg <= 8'd0;
      toutHiCfg  <= 8'hFF;
    end else if (grpHit) begin
      case (sub)
        3'd0:    halfCfg    <= bus.iDATA;
        3'd1:    pulsesCfg  <= bus.iDATA;
        3'd2:    blankLoCfg <= bus.iDATA;
        3'd3:    blankHiCfg <= bus.iDATA;
        3'd4:    toutHiCfg  <= bus.iDATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    oPIEZO_TX = 1'b0;
    oPIEZO_EN = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE:   if (startAcc) stateNext = TX;
      TX: begin
        oPIEZO_EN = 1'b1;
        oPIEZO_TX = txLevel;
        if (halfTick && lastHalf) stateNext = BLANK;
      end
      BLANK:  if (blankCnt <= 16'd1) stateNext = LISTEN;
      LISTEN: if (rxEdge || timeoutHit) stateNext = DONE;
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (abortNow) stateNext = IDLE;
  end

  // 2-flop synchronizer plus registered edge: a rise first seen in cycle k reaches LISTEN at k+3
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      rxMeta <= 1'b0;
      rxSync <= 1'b0;
      rxPrev <= 1'b0;
      rxEdge <= 1'b0;
    end else begin
      rxMeta <= iPIEZO_RX;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
      rxEdge <= rxSync && !rxPrev;
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      halfW    <= '0;
      pulsesW  <= '0;
      toutW    <= '0;
      halfCnt  <= '0;
      halfIdx  <= '0;
      blankCnt <= '0;
      txLevel  <= 1'b0;
      cnt      <= '0;
      tof      <= '0;
    end else begin
      if (startAcc) begin
        halfW    <= halfCfg;
        pulsesW  <= pulsesCfg;
        toutW    <= CNT_W'({toutHiCfg, 8'hFF});
        blankCnt <= {blankHiCfg, blankLoCfg};
        halfCnt  <= '0;
        halfIdx  <= '0;
        txLevel  <= 1'b1;
        cnt      <= '0;
      end else begin
        if (state == TX) begin
          if (halfTick) begin
            halfCnt <= '0;
            halfIdx <= halfIdx + 9'd1;
            txLevel <= !txLevel;
          end else begin
            halfCnt <= halfCnt + 8'd1;
          end
        end
        if (state == BLANK && blankCnt != 16'd0) blankCnt <= blankCnt - 16'd1;
        if ((state == TX || state == BLANK || state == LISTEN) && !cntSat) cnt <= cnt + CNT_W'(1);
      end
      if (state == LISTEN && !abortNow) begin
        if (rxEdge)          tof <= cnt;
        else if (timeoutHit) tof <= '1;
      end
    end
  end

  // later assignments win: clear, then start, then this cycle's events
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      hit      <= 1'b0;
      tout     <= 1'b0;
      aborted  <= 1'b0;
      overrun  <= 1'b0;
      paramErr <= 1'b0;
    end else begin
      if (clearReq) begin
        hit      <= 1'b0;
        tout     <= 1'b0;
        aborted  <= 1'b0;
        overrun  <= 1'b0;
        paramErr <= 1'b0;
      end
      if (startAcc) begin
        hit     <= 1'b0;
        tout    <= 1'b0;
        aborted <= 1'b0;
      end
      if (state == LISTEN && !abortNow) begin
        if (rxEdge)          hit  <= 1'b1;
        else if (timeoutHit) tout <= 1'b1;
      end
      if (abortNow) aborted <= 1'b1;
      if (startReq && !idle) overrun <= 1'b1;
      if (startReq && idle && !paramOk) paramErr <= 1'b1;
    end
  end

  assign bus.oTOF    = tof;
  assign bus.oSTATUS = {2'b00, paramErr, overrun, aborted, tout, hit, busy};
  assign bus.oBUSY   = busy;
  assign bus.oDONE   = done;

endmodule
